// File: rtl/tmds_pkg.sv
// TMDS encoder shared constants.
// Widths for data, symbol and running disparity.
package tmds_pkg;

  localparam int DATA_W   = 8;
  localparam int SYM_W    = 10;
  localparam int RD_W_DEF = 6;

  // Internal disparity width: room for rd_in plus a +/-9 step.
  function automatic int disp_iw(input int rd_w);
    return (rd_w + 2 > 6) ? rd_w + 2 : 6;
  endfunction

endpackage

// File: rtl/tmds_popcount8.sv
// Eight-bit population count.
// Used for both the data byte and the transition-minimised word.
module tmds_popcount8
  import tmds_pkg::*;
(
  input  logic [DATA_W-1:0] d_i,
  output logic [3:0]        cnt_o
);

  always_comb begin
    cnt_o = 4'd0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt_o = cnt_o + {3'b000, d_i[i]};
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS 8b/10b symbol encoder.
// Combinational encode with a registered copy of symbol and disparity.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int RD_W = RD_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      D,
  input  logic signed [RD_W-1:0] rd_in,
  output logic [SYM_W-1:0]       tmds_out,
  output logic signed [RD_W-1:0] rd_out,
  output logic [SYM_W-1:0]       tmds_q,
  output logic signed [RD_W-1:0] rd_q
);

  localparam int IW = disp_iw(RD_W);
  localparam logic signed [IW-1:0] ONE   = IW'(1);
  localparam logic signed [IW-1:0] EIGHT = IW'(8);

  logic [3:0]          n1d;
  logic [3:0]          n1q;
  logic                inv;
  logic [DATA_W:0]     qm;
  logic signed [IW-1:0] rd_x;
  logic signed [IW-1:0] bal;
  logic signed [IW-1:0] rd_d;
  logic                rd_zero;
  logic                rd_neg;
  logic                rd_pos;
  logic                bal_zero;
  logic [SYM_W-1:0]    sym_d;

  tmds_popcount8 u_pc_d (
    .d_i   (D),
    .cnt_o (n1d)
  );

  tmds_popcount8 u_pc_q (
    .d_i   (qm[DATA_W-1:0]),
    .cnt_o (n1q)
  );

  // Stage 1: XOR or XNOR chain, whichever gives fewer transitions.
  always_comb begin
    inv   = (n1d > 4'd4) || ((n1d == 4'd4) && !D[0]);
    qm    = '0;
    qm[0] = D[0];
    for (int i = 1; i < DATA_W; i++) begin
      qm[i] = inv ? ~(qm[i-1] ^ D[i])
                  :  (qm[i-1] ^ D[i]);
    end
    qm[DATA_W] = ~inv;
  end

  // Stage 2: DC balance against the running disparity.
  always_comb begin
    rd_x     = IW'(rd_in);
    bal      = $signed(IW'({n1q, 1'b0})) - EIGHT;
    rd_zero  = (rd_in == '0);
    rd_neg   = rd_in[RD_W-1];
    rd_pos   = !rd_neg && !rd_zero;
    bal_zero = (n1q == 4'd4);
    sym_d    = '0;
    rd_d     = rd_x;
    unique case (1'b1)
      rd_zero || bal_zero: begin
        sym_d[9] = ~qm[8];
        sym_d[8] = qm[8];
        if (qm[8]) begin
          sym_d[7:0] = qm[7:0];
          rd_d       = rd_x + bal;
        end else begin
          sym_d[7:0] = ~qm[7:0];
          rd_d       = rd_x - bal;
        end
      end
      (rd_pos && (n1q > 4'd4)) ||
      (rd_neg && (n1q < 4'd4)): begin
        sym_d = {1'b1, qm[8], ~qm[7:0]};
        rd_d  = qm[8] ? (rd_x - bal - ONE)
                      : (rd_x - bal + ONE);
      end
      default: begin
        sym_d = {1'b0, qm[8], qm[7:0]};
        rd_d  = qm[8] ? (rd_x + bal + ONE)
                      : (rd_x + bal - ONE);
      end
    endcase
  end

  assign tmds_out = sym_d;
  assign rd_out   = rd_d[RD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmds_q <= '0;
      rd_q   <= '0;
    end else begin
      tmds_q <= tmds_out;
      rd_q   <= rd_out;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed vectors, chained sweep,
// random vectors against an arithmetic model, reset behaviour.
module tb_tmds_encoder;

  logic              clk;
  logic              rst_n;
  logic [7:0]        D;
  logic signed [5:0] rd_in;
  logic [9:0]        tmds_out;
  logic signed [5:0] rd_out;
  logic [9:0]        tmds_q;
  logic signed [5:0] rd_q;

  int errors = 0;
  int checks = 0;

  tmds_encoder #(.RD_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D        (D),
    .rd_in    (rd_in),
    .tmds_out (tmds_out),
    .rd_out   (rd_out),
    .tmds_q   (tmds_q),
    .rd_q     (rd_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic void model(input int d, input int rd,
                                output int sym, output int rdo);
    int n1d, n1q, n0q, w, r;
    bit inv, q8;
    bit qm[8];
    n1d = 0;
    for (int i = 0; i < 8; i++) n1d += (d >> i) & 1;
    inv = (n1d > 4) || (n1d == 4 && (d & 1) == 0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = qm[i-1] ^ d[i];
      if (inv) qm[i] = !qm[i];
    end
    q8 = !inv;
    w = 0;
    n1q = 0;
    for (int i = 0; i < 8; i++) begin
      w += int'(qm[i]) << i;
      n1q += int'(qm[i]);
    end
    n0q = 8 - n1q;
    if (rd == 0 || n1q == n0q) begin
      if (q8) begin
        sym = 256 + w;
        r = rd + n1q - n0q;
      end else begin
        sym = 512 + (255 - w);
        r = rd + n0q - n1q;
      end
    end else if ((rd > 0 && n1q > n0q) || (rd < 0 && n1q < n0q)) begin
      sym = 512 + int'(q8) * 256 + (255 - w);
      r = rd + n0q - n1q + (q8 ? -1 : 1);
    end else begin
      sym = int'(q8) * 256 + w;
      r = rd + n1q - n0q + (q8 ? 1 : -1);
    end
    r = ((r % 64) + 64) % 64;
    if (r >= 32) r -= 64;
    rdo = r;
  endfunction

  int dv_d[5]   = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h55};
  int dv_rd[5]  = '{0, -8, 3, 0, 5};
  int dv_sym[5] = '{10'h100, 10'h3FF, 10'h100, 10'h200, 10'h133};
  int dv_ro[5]  = '{-8, -1, -4, -8, 5};

  initial begin
    int es, er, rd, ps, pr;
    rst_n = 1'b0;
    D     = 8'h00;
    rd_in = 6'sd0;
    #2;
    chk("rst_tmds_q", int'(tmds_q), 0);
    chk("rst_rd_q", int'(rd_q), 0);
    chk("rst_comb_sym", int'(tmds_out), 10'h100);
    chk("rst_comb_rd", int'(rd_out), -8);
    #10;
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      D = 8'(dv_d[k]);
      rd_in = 6'(dv_rd[k]);
      #1;
      chk($sformatf("dir%0d_sym", k), int'(tmds_out), dv_sym[k]);
      chk($sformatf("dir%0d_rd", k), int'(rd_out), dv_ro[k]);
    end

    rd = 0;
    for (int p = 0; p < 3; p++) begin
      for (int d = 0; d < 256; d++) begin
        model(d, rd, es, er);
        D = 8'(d);
        rd_in = 6'(rd);
        #1;
        chk($sformatf("swp%0d_%0d_sym", p, d), int'(tmds_out), es);
        chk($sformatf("swp%0d_%0d_rd", p, d), int'(rd_out), er);
        rd = er;
      end
    end

    for (int k = 0; k < 12; k++) begin
      model(k * 37 % 256, -32, es, er);
      D = 8'(k * 37 % 256);
      rd_in = 6'sh20;
      #1;
      chk($sformatf("neg32_%0d_sym", k), int'(tmds_out), es);
      chk($sformatf("neg32_%0d_rd", k), int'(rd_out), er);
    end

    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      int d;
      d  = int'($urandom_range(0, 255));
      rd = int'($urandom_range(0, 63));
      if (rd >= 32) rd -= 64;
      model(d, rd, es, er);
      D = 8'(d);
      rd_in = 6'(rd);
      #1;
      chk($sformatf("rnd%0d_sym", k), int'(tmds_out), es);
      chk($sformatf("rnd%0d_rd", k), int'(rd_out), er);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_tmds_q", k), int'(tmds_q), es);
      chk($sformatf("rnd%0d_rd_q", k), int'(rd_q), er);
      ps = es;
      pr = er;
    end

    D = 8'hFF;
    rd_in = 6'sd7;
    model(255, 7, es, er);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tmds_q", int'(tmds_q), 0);
    chk("mid_rst_rd_q", int'(rd_q), 0);
    chk("mid_rst_comb_sym", int'(tmds_out), es);
    chk("mid_rst_comb_rd", int'(rd_out), er);
    @(posedge clk);
    #1;
    chk("held_rst_tmds_q", int'(tmds_q), 0);
    D = 8'h00;
    rd_in = 6'sd0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_tmds_q", int'(tmds_q), 10'h100);
    chk("post_rst_rd_q", int'(rd_q), -8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 Parameter RD_W, default 6: running-disparity width in bits, signed two's complement.
REQ-002 clk  input  1  sole clock; rising edge active.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 D  input  8  data byte to encode.
REQ-005 rd_in  input  RD_W  signed running disparity before this symbol.
REQ-006 tmds_out  output  10  combinational TMDS symbol for D/rd_in.
REQ-007 rd_out  output  RD_W  combinational signed running disparity after this symbol.
REQ-008 tmds_q  output  10  tmds_out registered on clk.
REQ-009 rd_q  output  RD_W  rd_out registered on clk.

Function
REQ-010 tmds_out/rd_out SHALL be purely combinational from D and rd_in: zero latency, independent of clk/rst_n.
REQ-011 N1d = popcount(D); invert = (N1d>4) or (N1d==4 and D[0]==0).
REQ-012 q_m[0]=D[0]; for i=1..7, q_m[i] = q_m[i-1] XOR D[i] when invert=0, XNOR when invert=1; q_m[8] = NOT invert.
REQ-013 N1q = popcount(q_m[7:0]); N0q = 8-N1q.
REQ-014 Case A (rd_in==0 or N1q==N0q): tmds[9]=~q_m[8], tmds[8]=q_m[8].
REQ-015 Case A, q_m[8]=1: tmds[7:0]=q_m[7:0], rd_out=rd_in+(N1q-N0q).
REQ-016 Case A, q_m[8]=0: tmds[7:0]=~q_m[7:0], rd_out=rd_in+(N0q-N1q).
REQ-017 Case B (otherwise): tmds[8]=q_m[8].
REQ-018 Case B invert when (rd_in>0 and N1q>N0q) or (rd_in<0 and N1q<N0q): tmds[9]=1, tmds[7:0]=~q_m[7:0], rd_out=rd_in+(N0q-N1q)-1 if q_m[8]=1, +1 if q_m[8]=0.
REQ-019 Case B keep otherwise: tmds[9]=0, tmds[7:0]=q_m[7:0], rd_out=rd_in+(N1q-N0q)+1 if q_m[8]=1, -1 if q_m[8]=0.
REQ-020 Disparity arithmetic SHALL be signed with at least RD_W+2 bits internally; rd_out SHALL be truncated to RD_W bits (modulo 2^RD_W wrap, no saturation).
REQ-021 rd_in sign tests SHALL use signed interpretation (e.g. 6'b100000 = -32).
REQ-022 On every rising clk edge with rst_n high, tmds_q<=tmds_out and rd_q<=rd_out.
REQ-023 No X SHALL propagate to outputs for any known D/rd_in.

Reset
REQ-024 rst_n low SHALL immediately force tmds_q=10'h000 and rd_q=0, independent of clk.
REQ-025 Reset SHALL NOT affect tmds_out/rd_out.
REQ-026 After deassertion, the first rising edge SHALL load the registers normally.

Structure
REQ-027 Package tmds_pkg SHALL hold RD_W default, symbol width 10, and data width 8 constants.
REQ-028 Sub-module tmds_popcount8 (8-bit in, 4-bit count out) SHALL be instantiated for both N1d and N1q.
REQ-029 The encoder core SHALL be one combinational block; registers in a separate always block.

Verification
REQ-030 D=8'h00, rd_in=0 -> tmds_out=10'h100, rd_out=-8.
REQ-031 D=8'h00, rd_in=-8 -> tmds_out=10'h3FF, rd_out=-1; D=8'h00, rd_in=+3 -> tmds_out=10'h100, rd_out=-4.
REQ-032 D=8'hFF, rd_in=0 -> tmds_out=10'h200, rd_out=-8; D=8'h55, rd_in=5 -> tmds_out=10'h133, rd_out=5.
REQ-033 Exhaustive: 3 passes of D=0..255 with rd_out fed back to rd_in, starting at 0; every tmds_out/rd_out matches a REQ-011..020 model.
REQ-034 Assert rst_n low mid-stream, no clk edge -> tmds_q=0, rd_q=0 at once; release, D=8'h00, rd_in=0, one edge -> tmds_q=10'h100, rd_q=-8.
